instr_fetch_buffer: RTL
=======================

Name: instr_fetch_buffer

Overview:
Fetch stage directly downstream of the program counter. Each cycle it takes the current PC and issues a read to the synchronous instruction memory. It pairs the returned instruction with its PC and queues the pair in a small FIFO. The pair is then handed to decode over a valid/ready handshake. It back-pressures the PC register through pc_stall, which drives the PC register's enable inverted, and it discards wrong-path work on flush, which is tied to the PC branch signal.

Parameters:
ADDR_W, 10, PC / instruction-memory address width
DATA_W, 16, instruction word width
DEPTH, 4, FIFO entries (power of two, >= 2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pc_in  in  ADDR_W  current PC from the program counter
flush  in  1  branch taken this cycle; kill in-flight and queued fetches
pc_stall  out  1  hold PC (PC register en = ~pc_stall)
imem_req  out  1  read strobe to instruction memory
imem_addr  out  ADDR_W  read address (= pc_in)
imem_rdata  in  DATA_W  read data, valid exactly 1 cycle after imem_req
out_valid  out  1  head entry available to decode
out_ready  in  1  decode accepts head entry
out_pc  out  ADDR_W  PC of head entry
out_instr  out  DATA_W  instruction of head entry
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset low, async):
  - count=0, rd/wr pointers=0, inflight_v=0, inflight_pc=0.
  - imem_req=0, out_valid=0, out_pc=0, out_instr=0, pc_stall=0.
- issue = reset & ~flush & (count + inflight_v < DEPTH).
  - Conservative: a same-cycle pop is not credited.
  - imem_req=issue; imem_addr=pc_in.
- pc_stall = ~issue & ~flush. Flush forces pc_stall=0 so the PC loads the branch target on that edge.
- On an issue edge: inflight_v<=1, inflight_pc<=pc_in. Otherwise inflight_v<=0.
- Next cycle, if inflight_v & ~flush: push {inflight_pc, imem_rdata}.
  - Base latency pc_in -> out_valid is 2 cycles.
- Pop when out_valid & out_ready.
  - Simultaneous push+pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Full: the credit rule guarantees no push when full. A push into a full FIFO is a design error (assertion).
- Empty: out_valid=0, and out_pc/out_instr are driven 0.
- Flush (synchronous, highest priority):
  - On the edge: count<=0, pointers<=0, inflight_v<=0.
  - The same-cycle push and pop are suppressed; out_ready is ignored.
  - out_valid is 0 from the following cycle.
  - No request is issued in the flush cycle. The first target fetch issues the cycle after, with pc_in = branch target.
- Back-to-back flushes: each one clears again; no entry escapes.
- Reset mid-operation: all state returns to reset values immediately. In-flight data returning after reset release is ignored because inflight_v=0.
- Output entry order equals issue order; no PC is duplicated or skipped except across a flush.

Optional Feature:
FETCH_BYPASS_EN:
- Defined: when the FIFO is empty and inflight_v & ~flush, the returning pair drives out_valid/out_pc/out_instr combinationally.
  - If out_ready=1, the pair is consumed without a push (latency 1 cycle).
  - If out_ready=0, it is pushed normally.
- Undefined: outputs come only from FIFO storage (latency 2, no memory-to-decode combinational path).

Decomposition:
- Package fetch_pkg:
  - ADDR_W and DATA_W defaults.
  - typedef fetch_entry_t {pc, instr}.
  - NOP_INSTR constant, used for reset/empty output values.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop and flush, plus count/full/empty outputs.
- The top level holds the issue/credit logic, the in-flight register and the optional bypass.

Test Plan:
1. Reset low then high; out_ready=1, memory returns 16'hA000+addr -> out_valid rises 2 cycles after the first issue; out_pc sequence 0,1,2,3; out_instr A000..A003; pc_stall=0 throughout.
2. out_ready=0 from start -> count reaches 4 with inflight_v=0; pc_stall=1 and imem_req=0 while full; pc_in held at 4. Raising out_ready -> entries 0..3 drain in order, then PC 4 follows.
3. Flush with pc_in=100 while count=3 -> count=0 and out_valid=0 next cycle; no request in the flush cycle; next outputs are PC 100, 101 with no stale entry.
4. Flush asserted in the cycle data for PC 7 returns -> PC 7 never appears at the output.
5. Assert reset low mid-stream with count=2 -> all outputs 0 asynchronously. After release, fetch restarts cleanly from the current pc_in.
6. FETCH_BYPASS_EN defined, empty FIFO, out_ready=1 -> out_valid 1 cycle after issue; count stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch buffer: entry layout,
// default widths/depth and the value driven on an empty or reset output.
package fetch_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_entry_t;

  localparam logic [DATA_W_DEF-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/instr_fetch_buffer_if.sv
// Fetch buffer bus bundle: instruction-memory read port plus the
// valid/ready decode handshake. master = fetch buffer, slave = its environment.
interface instr_fetch_buffer_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_instr;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
    input  imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
    output imem_rdata, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a flush that empties it in one
// edge. The head entry is presented combinationally from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  entry_t           din,
  input  logic             pop,
  output entry_t           dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues one imem read per cycle while FIFO credit allows, pairs
// the returning word with its PC and queues it for decode. Define
// FETCH_BYPASS_EN to forward a returning pair straight to decode when empty.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int  ADDR_W = ADDR_W_DEF,
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       pc_in,
  input  logic                    flush,
  output logic                    pc_stall,
  instr_fetch_buffer_if.master    bus,
  output logic [CNT_W-1:0]        count
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic              inflight_v_q, inflight_v_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

  logic              issue, ret_v, push, pop, head_v;
  logic [CNT_W:0]    occupancy;
  entry_t            ret_entry, fifo_dout, head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;

  // Credit counts the in-flight read but never a same-cycle pop
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_v_q};
  assign issue     = reset & ~flush & (occupancy < (CNT_W+1)'(DEPTH));
  assign pc_stall  = reset & ~issue & ~flush;
  assign ret_v     = inflight_v_q & ~flush;
  assign ret_entry = '{pc: inflight_pc_q, instr: bus.imem_rdata};

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_in;

  always_comb begin
    inflight_v_d  = issue;
    inflight_pc_d = inflight_pc_q;
    if (issue) inflight_pc_d = pc_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  always_comb begin
    push   = ret_v;
    head   = fifo_dout;
    head_v = ~fifo_empty;
    pop    = ~fifo_empty & bus.out_ready & ~flush;
`ifdef FETCH_BYPASS_EN
    if (fifo_empty && ret_v) begin
      head   = ret_entry;
      head_v = 1'b1;
      push   = ~bus.out_ready;
    end
`endif
  end

  assign bus.out_valid = head_v;
  assign bus.out_pc    = head_v ? head.pc : '0;
  assign bus.out_instr = head_v ? head.instr : DATA_W'(NOP_INSTR);
  assign count         = fifo_count;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .din   (ret_entry),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));

endmodule
